acc_to_bf16_pipe: RTL and testbench
===================================

Name: acc_to_bf16_pipe

Overview:
- Multi-lane, pipelined converter from signed integer accumulator words to bfloat16.
- Parametrised successor of the combinational int20→bf16 normaliser. Adds configurable width and lane count, a per-beat runtime exponent shift, round-to-nearest-even, overflow/underflow handling, and a sticky range flag.
- Sits between the systolic-array accumulator drain and the output writeback. Uses a valid/ready handshake on both sides.

Parameters:
- ACC_W, 20, accumulator width in bits (signed two's complement, ≥8).
- LANES, 4, independent conversion lanes per beat.
- EXP_OFFSET, 24, fixed binary-point offset subtracted from the exponent (signed integer).
- ROUND_MODE, 1, 0 = truncate, 1 = round-to-nearest-even.
- SATURATE, 1, on overflow: 1 = ±max finite (0x7F7F/0xFF7F), 0 = ±inf (0x7F80/0xFF80).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, converter can accept a beat.
- in_acc, input, LANES*ACC_W, packed accumulators; lane i at [i*ACC_W +: ACC_W].
- in_shift, input, 8, signed exponent adjust applied to every lane of the beat.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts.
- out_bf16, output, LANES*16, packed results; lane i at [i*16 +: 16].
- flag_clr, input, 1, clears range_flag.
- range_flag, output, 1, sticky: set if any lane of any accepted beat overflowed or underflowed.

Behaviour:
- Clock and reset:
  - Single clock domain (clk).
  - Reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - All stage valid bits = 0, out_valid = 0, out_bf16 = 0, range_flag = 0.
  - Reset mid-operation discards all in-flight beats.
- Pipeline:
  - 3 register stages.
    - S1: capture sign, magnitude (ACC_W-bit unsigned) and in_shift.
    - S2: leading-one position `lead`, left-normalise so the leading one sits at the MSB; compute unbiased exponent.
    - S3: round, exponent check, assemble.
  - Latency: 3 cycles from the in_valid&in_ready edge to out_valid, with no backpressure.
  - Throughput: 1 beat/cycle.
- Handshake:
  - Stage k loads when stage k is empty or stage k+1 loads/drains; the output stage drains on out_valid&out_ready.
  - in_ready = !s1_valid | s1_advances. A combinational path from out_ready to in_ready is permitted.
  - out_bf16 must hold stable while out_valid & !out_ready.
  - Beats are never dropped or duplicated.
- Arithmetic, per lane:
  - sign = msb.
  - mag = |acc|. The most negative value gives mag = 2^(ACC_W-1) without overflow.
  - If mag == 0, output 0x0000 (positive zero regardless of shift). The flag is not set.
  - Exponent e = lead + 127 − EXP_OFFSET + in_shift, computed signed at ≥ 11 bits.
  - Mantissa m = 7 bits immediately below the leading one, zero-padded when lead < 7.
  - Rounding:
    - guard = next bit below m; sticky = OR of all lower bits.
    - ROUND_MODE=1: increment m if guard & (sticky | m[0]). If m overflows, m = 0 and e += 1.
    - ROUND_MODE=0: truncate.
  - Range check after rounding:
    - e ≥ 255: overflow. Output {sign, SATURATE ? 0x7F7F-pattern : 0x7F80-pattern}.
    - e ≤ 0: underflow. Output {sign, 15'b0}; no subnormals.
    - Either case sets range_flag when the beat leaves S3.
  - Otherwise output {sign, e[7:0], m}.
- range_flag:
  - Set takes priority over flag_clr in the same cycle.
  - Otherwise flag_clr clears it on the next edge.
- Lanes are fully independent except for the shared in_shift and the shared handshake.

Test Plan:
1. Defaults. Lane accs {1, −1, 0, 0x80000 (−2^19)}, shift 0 → out lanes {0x3380, 0xB380, 0x0000, 0xBD00}, 3 cycles after acceptance.
2. RNE, shift 0. accs {0x1FF, 0x101, 0x103, 0x7FFFF} → {0x3800, 0x3780, 0x3782, 0x3D00}. Same accs with ROUND_MODE=0 → {0x37FF, 0x3780, 0x3781, 0x3CFF}.
3. EXP_OFFSET=0, SATURATE=1. acc 0x40000, shift +110 → 0x7F7F and range_flag=1. With SATURATE=0 → 0x7F80. Then flag_clr pulse → range_flag=0.
4. acc 1, shift −103 (defaults) → 0x0000, range_flag=1. acc −1, shift −103 → 0x8000.
5. Stream of 10 beats with out_ready toggling pseudo-randomly (including held low for 5 cycles).
   - All 10 outputs emerge in order, matching the model.
   - out_bf16 is stable while stalled.
   - in_ready deasserts once 3 beats are buffered.
6. rst_n low for one cycle with 2 beats in flight → out_valid=0 next cycle, no stale beat is emitted, range_flag=0.

Source files
------------

// File: rtl/acc_to_bf16_pipe.sv
// ============================================================================
// Module   : acc_to_bf16_pipe
// Purpose  : multi-lane, 3-stage signed-accumulator to bfloat16 converter
// Revision : 1.0
// ============================================================================
`default_nettype none

module acc_to_bf16_pipe #(
  parameter int ACC_W      = 20,
  parameter int LANES      = 4,
  parameter int EXP_OFFSET = 24,
  parameter int ROUND_MODE = 1,
  parameter int SATURATE   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_acc,
  input  logic [7:0]             in_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*16-1:0]    out_bf16,
  input  logic                   flag_clr,
  output logic                   range_flag
);

  localparam int LW = $clog2(ACC_W);
  localparam int EW = 16;
  localparam int XW = ACC_W + 8;
  localparam logic signed [EW-1:0] EXP_BIAS = EW'(127 - EXP_OFFSET);
  localparam logic signed [EW-1:0] EXP_MAX  = 16'sd255;
  localparam logic signed [EW-1:0] EXP_MIN  = 16'sd0;
  localparam logic [14:0] OVF_PATTERN = (SATURATE != 0) ? 15'h7F7F : 15'h7F80;

  logic             s1_valid_d, s1_valid_q;
  logic             s2_valid_d, s2_valid_q;
  logic             s3_valid_d, s3_valid_q;
  logic [7:0]       s1_shift_d, s1_shift_q;
  logic             range_flag_d, range_flag_q;
  logic             s1_ready, s2_ready, s3_ready;
  logic             s1_load, s2_load, s3_load, s3_drain;
  logic [LANES-1:0] lane_range;

  always_comb begin
    s3_ready     = !s3_valid_q || out_ready;
    s2_ready     = !s2_valid_q || s3_ready;
    s1_ready     = !s1_valid_q || s2_ready;
    s1_load      = in_valid && s1_ready;
    s2_load      = s1_valid_q && s2_ready;
    s3_load      = s2_valid_q && s3_ready;
    s3_drain     = s3_valid_q && out_ready;
    s1_valid_d   = s1_ready ? in_valid : s1_valid_q;
    s2_valid_d   = s2_ready ? s1_valid_q : s2_valid_q;
    s3_valid_d   = s3_ready ? s2_valid_q : s3_valid_q;
    s1_shift_d   = s1_load ? in_shift : s1_shift_q;
    range_flag_d = range_flag_q;
    // a range event on the departing beat wins over a same-cycle clear
    if (s3_drain && (|lane_range)) begin
      range_flag_d = 1'b1;
    end else if (flag_clr) begin
      range_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s3_valid_q   <= 1'b0;
      s1_shift_q   <= 8'h00;
      range_flag_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s3_valid_q   <= s3_valid_d;
      s1_shift_q   <= s1_shift_d;
      range_flag_q <= range_flag_d;
    end
  end

  assign in_ready   = s1_ready;
  assign out_valid  = s3_valid_q;
  assign range_flag = range_flag_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ACC_W-1:0]        acc;
    logic                    s1_sign_d, s1_sign_q;
    logic [ACC_W-1:0]        s1_mag_d, s1_mag_q;
    logic [LW-1:0]           lead;
    logic                    s2_sign_d, s2_sign_q;
    logic                    s2_zero_d, s2_zero_q;
    logic [ACC_W-2:0]        s2_frac_d, s2_frac_q;
    logic signed [EW-1:0]    s2_exp_d, s2_exp_q;
    logic [XW-1:0]           ext;
    logic [6:0]              mant;
    logic                    guard, sticky, round_up;
    logic [7:0]              mant_inc;
    logic signed [EW-1:0]    exp_r;
    logic [15:0]             s3_bf16_d, s3_bf16_q;
    logic                    s3_range_d, s3_range_q;

    // S1: sign/magnitude; the most negative input maps to 2^(ACC_W-1) unsigned
    always_comb begin
      acc       = in_acc[i*ACC_W +: ACC_W];
      s1_sign_d = s1_sign_q;
      s1_mag_d  = s1_mag_q;
      if (s1_load) begin
        s1_sign_d = acc[ACC_W-1];
        s1_mag_d  = acc[ACC_W-1] ? (~acc + ACC_W'(1)) : acc;
      end
    end

    // S2: leading-one detect; keep only the bits below the leading one
    always_comb begin
      lead = '0;
      for (int b = 0; b < ACC_W; b++) begin
        if (s1_mag_q[b]) lead = LW'(b);
      end
      s2_sign_d = s2_sign_q;
      s2_zero_d = s2_zero_q;
      s2_frac_d = s2_frac_q;
      s2_exp_d  = s2_exp_q;
      if (s2_load) begin
        s2_sign_d = s1_sign_q;
        s2_zero_d = (s1_mag_q == '0);
        s2_frac_d = s1_mag_q[ACC_W-2:0] << (LW'(ACC_W-1) - lead);
        s2_exp_d  = $signed({{(EW-LW){1'b0}}, lead}) + EXP_BIAS
                  + $signed({{(EW-8){s1_shift_q[7]}}, s1_shift_q});
      end
    end

    // S3: round, range check, assemble
    always_comb begin
      ext        = {s2_frac_q, 9'b0};
      mant       = ext[XW-1 -: 7];
      guard      = ext[XW-8];
      sticky     = |ext[XW-9:0];
      round_up   = (ROUND_MODE != 0) && guard && (sticky || mant[0]);
      mant_inc   = {1'b0, mant} + {7'b0, round_up};
      exp_r      = s2_exp_q + $signed({{(EW-1){1'b0}}, mant_inc[7]});
      s3_bf16_d  = s3_bf16_q;
      s3_range_d = s3_range_q;
      if (s3_load) begin
        if (s2_zero_q) begin
          s3_bf16_d  = 16'h0000;
          s3_range_d = 1'b0;
        end else if (exp_r >= EXP_MAX) begin
          s3_bf16_d  = {s2_sign_q, OVF_PATTERN};
          s3_range_d = 1'b1;
        end else if (exp_r <= EXP_MIN) begin
          s3_bf16_d  = {s2_sign_q, 15'h0000};
          s3_range_d = 1'b1;
        end else begin
          s3_bf16_d  = {s2_sign_q, exp_r[7:0], mant_inc[6:0]};
          s3_range_d = 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_sign_q  <= 1'b0;
        s1_mag_q   <= '0;
        s2_sign_q  <= 1'b0;
        s2_zero_q  <= 1'b0;
        s2_frac_q  <= '0;
        s2_exp_q   <= '0;
        s3_bf16_q  <= 16'h0000;
        s3_range_q <= 1'b0;
      end else begin
        s1_sign_q  <= s1_sign_d;
        s1_mag_q   <= s1_mag_d;
        s2_sign_q  <= s2_sign_d;
        s2_zero_q  <= s2_zero_d;
        s2_frac_q  <= s2_frac_d;
        s2_exp_q   <= s2_exp_d;
        s3_bf16_q  <= s3_bf16_d;
        s3_range_q <= s3_range_d;
      end
    end

    assign out_bf16[i*16 +: 16] = s3_bf16_q;
    assign lane_range[i]        = s3_range_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_acc_to_bf16_pipe.sv
// ============================================================================
// Module   : tb_acc_to_bf16_pipe
// Purpose  : directed self-checking bench for acc_to_bf16_pipe
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_acc_to_bf16_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [79:0] in_acc;
  logic [7:0]  in_shift;
  logic        out_ready;
  logic        flag_clr;

  logic        in_ready_m, out_valid_m, flag_m;
  logic [63:0] out_bf16_m;
  logic        in_ready_t, out_valid_t, flag_t;
  logic [63:0] out_bf16_t;
  logic        in_ready_s, out_valid_s, flag_s;
  logic [63:0] out_bf16_s;
  logic        in_ready_i, out_valid_i, flag_i;
  logic [63:0] out_bf16_i;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  acc_to_bf16_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_acc(in_acc), .in_shift(in_shift), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_bf16(out_bf16_m), .flag_clr(flag_clr),
    .range_flag(flag_m)
  );

  acc_to_bf16_pipe #(.ROUND_MODE(0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_acc(in_acc), .in_shift(in_shift), .out_valid(out_valid_t),
    .out_ready(out_ready), .out_bf16(out_bf16_t), .flag_clr(flag_clr),
    .range_flag(flag_t)
  );

  acc_to_bf16_pipe #(.EXP_OFFSET(0), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_acc(in_acc), .in_shift(in_shift), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_bf16(out_bf16_s), .flag_clr(flag_clr),
    .range_flag(flag_s)
  );

  acc_to_bf16_pipe #(.EXP_OFFSET(0), .SATURATE(0)) dut_inf (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_i),
    .in_acc(in_acc), .in_shift(in_shift), .out_valid(out_valid_i),
    .out_ready(out_ready), .out_bf16(out_bf16_i), .flag_clr(flag_clr),
    .range_flag(flag_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-beat pulse; callers only use it when the pipe can accept
  task automatic send(input logic [79:0] acc, input logic [7:0] sh);
    in_acc   = acc;
    in_shift = sh;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid_m && n < 10) begin
      tick();
      n++;
    end
    chk(tag, out_valid_m, 1'b1);
  endtask

  logic [63:0] exp_out [10];
  logic [15:0] ea, ed;
  logic [63:0] held;
  logic [39:0] pat;
  logic        stalled;
  int          snd, rcv, inflight, cyc, stale;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_acc    = '0;
    in_shift  = 8'h00;
    out_ready = 1'b1;
    flag_clr  = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid_m, 1'b0);
    chk("rst_out_bf16", out_bf16_m, 64'h0);
    chk("rst_range_flag", flag_m, 1'b0);
    chk("rst_in_ready", in_ready_m, 1'b1);
    rst_n = 1'b1;
    tick();

    // defaults: {-2^19, 0, -1, 1}, latency counted in edges from acceptance
    send({20'h80000, 20'h00000, 20'hFFFFF, 20'h00001}, 8'h00);
    chk("lat_edge1_valid", out_valid_m, 1'b0);
    tick();
    chk("lat_edge2_valid", out_valid_m, 1'b0);
    tick();
    chk("lat_edge3_valid", out_valid_m, 1'b1);
    chk("t1_defaults", out_bf16_m, 64'hBD00_0000_B380_3380);
    tick();
    chk("t1_drained", out_valid_m, 1'b0);

    // rounding vs truncation
    send({20'h7FFFF, 20'h00103, 20'h00101, 20'h001FF}, 8'h00);
    wait_out("t2_valid");
    chk("t2_rne", out_bf16_m, 64'h3D00_3782_3780_3800);
    chk("t2_trunc", out_bf16_t, 64'h3CFF_3781_3780_37FF);
    tick();

    // overflow with EXP_OFFSET=0, shift +110
    send({60'h0, 20'h40000}, 8'd110);
    wait_out("t3_valid");
    chk("t3_sat", out_bf16_s, 64'h0000_0000_0000_7F7F);
    chk("t3_inf", out_bf16_i, 64'h0000_0000_0000_7F80);
    chk("t3_main_inrange", out_bf16_m, 64'h0000_0000_0000_7380);
    chk("t3_flag_before_leave", flag_s, 1'b0);
    tick();
    chk("t3_flag_sat", flag_s, 1'b1);
    chk("t3_flag_inf", flag_i, 1'b1);
    chk("t3_flag_main", flag_m, 1'b0);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("t3_flag_clr", flag_s, 1'b0);

    // underflow: +/-1 with shift -103
    send({20'h00000, 20'h00000, 20'hFFFFF, 20'h00001}, 8'h99);
    wait_out("t4_valid");
    chk("t4_underflow", out_bf16_m, 64'h0000_0000_8000_0000);
    tick();
    chk("t4_flag", flag_m, 1'b1);

    // stream of 10 beats under a stalling consumer
    for (int k = 0; k < 10; k++) begin
      ea = 16'((103 + k) << 7);
      ed = 16'(((104 + k) << 7) | 'h40);
      exp_out[k] = {ed, 16'h0000, 16'h8000 | ea, ea};
    end
    pat        = '1;
    pat[4:0]   = '0;
    pat[6]     = 1'b0;
    pat[10:9]  = 2'b00;
    pat[12]    = 1'b0;
    pat[15]    = 1'b0;
    snd = 0; rcv = 0; inflight = 0; cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (rcv < 10 && cyc < 80) begin
      if (stalled) begin
        chk("t5_hold_bf16", out_bf16_m, held);
        chk("t5_hold_valid", out_valid_m, 1'b1);
      end
      out_ready = (cyc < 40) ? pat[cyc] : 1'b1;
      in_valid  = (snd < 10);
      if (snd < 10) begin
        in_acc   = {20'(3 << snd), 20'h00000, 20'(-(1 << snd)), 20'(1 << snd)};
        in_shift = 8'h00;
      end
      #1;
      chk("t5_in_ready", in_ready_m, (inflight < 3) || out_ready);
      if (out_valid_m && out_ready) begin
        if (rcv < 10) chk("t5_out", out_bf16_m, exp_out[rcv]);
        rcv++;
        inflight--;
      end
      if (in_valid && in_ready_m) begin
        snd++;
        inflight++;
      end
      stalled = out_valid_m && !out_ready;
      held    = out_bf16_m;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t5_count", 64'(rcv), 64'd10);
    tick();

    // reset with two beats in flight
    chk("t6_flag_pre", flag_m, 1'b1);
    send({20'h00005, 20'h00006, 20'h00007, 20'h00008}, 8'h00);
    send({20'h00009, 20'h0000A, 20'h0000B, 20'h0000C}, 8'h00);
    rst_n = 1'b0;
    tick();
    chk("t6_out_valid", out_valid_m, 1'b0);
    chk("t6_out_bf16", out_bf16_m, 64'h0);
    chk("t6_flag", flag_m, 1'b0);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      tick();
      if (out_valid_m) stale++;
    end
    chk("t6_no_stale", 64'(stale), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
